// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator write-side controller.
package acc_pkg;

    localparam int ACC_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_CLR  = 3'b111
    } acc_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WRITE,
        SETTLE
    } acc_drv_state_t;

endpackage

// File: rtl/acc_driver_if.sv
// Operation handshake plus accumulator write/feedback port of acc_driver.
interface acc_driver_if #(parameter int WIDTH = acc_pkg::ACC_WIDTH);

    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] acc_q;
    logic             wacc;
    logic [WIDTH-1:0] acc_d;
    logic             done;
    logic             carry;
    logic             zero;

    modport master (
        output op_valid, op_code, op_data, acc_q,
        input  op_ready, wacc, acc_d, done, carry, zero
    );

    modport slave (
        input  op_valid, op_code, op_data, acc_q,
        output op_ready, wacc, acc_d, done, carry, zero
    );

endinterface

// File: rtl/acc_alu.sv
// Combinational result/carry/zero for one accumulator operation.
// ACC_DRIVER_SAT_EN: ADD clamps to all-ones on carry, SUB clamps to 0 on borrow.
module acc_alu
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  acc_op_t          op,
    input  logic [WIDTH-1:0] acc_q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, operand};
        diff   = {1'b0, acc_q} - {1'b0, operand};
        result = acc_q;
        carry  = 1'b0;
        unique case (op)
            OP_NOP:  result = acc_q;
            OP_LOAD: result = operand;
            OP_ADD: begin
                carry = sum[WIDTH];
`ifdef ACC_DRIVER_SAT_EN
                result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
                result = sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                carry = diff[WIDTH];
`ifdef ACC_DRIVER_SAT_EN
                result = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
                result = diff[WIDTH-1:0];
`endif
            end
            OP_AND:  result = acc_q & operand;
            OP_OR:   result = acc_q | operand;
            OP_XOR:  result = acc_q ^ operand;
            OP_CLR:  result = '0;
            default: result = acc_q;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/acc_driver.sv
// Write-side controller for the accumulator: accept, compute, one-cycle write, done.
// Build option ACC_DRIVER_SAT_EN selects saturating ADD/SUB inside acc_alu.
module acc_driver
    import acc_pkg::*;
#(
    parameter int WIDTH = ACC_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    acc_driver_if.slave  bus
);

    acc_drv_state_t   state;
    acc_op_t          op_r;
    logic [WIDTH-1:0] data_r;

    logic             op_ready_r;
    logic             wacc_r;
    logic [WIDTH-1:0] acc_d_r;
    logic             done_r;
    logic             carry_r;
    logic             zero_r;

    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;

    acc_alu #(.WIDTH(WIDTH)) u_alu (
        .op      (op_r),
        .acc_q   (bus.acc_q),
        .operand (data_r),
        .result  (alu_result),
        .carry   (alu_carry),
        .zero    (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_r       <= OP_NOP;
            data_r     <= '0;
            op_ready_r <= 1'b1;
            wacc_r     <= 1'b0;
            acc_d_r    <= '0;
            done_r     <= 1'b0;
            carry_r    <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        op_r       <= acc_op_t'(bus.op_code);
                        data_r     <= bus.op_data;
                        op_ready_r <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // acc_q is sampled here; NOP skips the write and keeps flags.
                    if (op_r == OP_NOP) begin
                        done_r <= 1'b1;
                        state  <= SETTLE;
                    end else begin
                        wacc_r  <= 1'b1;
                        acc_d_r <= alu_result;
                        carry_r <= alu_carry;
                        zero_r  <= alu_zero;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    wacc_r <= 1'b0;
                    done_r <= 1'b1;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    done_r     <= 1'b0;
                    op_ready_r <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.op_ready = op_ready_r;
    assign bus.wacc     = wacc_r;
    assign bus.acc_d    = acc_d_r;
    assign bus.done     = done_r;
    assign bus.carry    = carry_r;
    assign bus.zero     = zero_r;

endmodule

// File: tb/tb_acc_driver.sv
// Directed bench for acc_driver with a cycle-schedule model and an accumulator register.
module tb_acc_driver;
    import acc_pkg::*;

`ifdef ACC_DRIVER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int N = 1024;

    logic clk = 1'b0;
    logic rst;
    logic [ACC_WIDTH-1:0] acc_reg = '0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    acc_driver_if #(.WIDTH(ACC_WIDTH)) bus ();

    acc_driver #(.WIDTH(ACC_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-cycle accumulator register; reset does not touch it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wacc === 1'b1) acc_reg <= bus.acc_d;
    end
    assign bus.acc_q = acc_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_op(input int code, input int a, input int d,
                                     output int r, output int c);
        int full;
        full = 1 << ACC_WIDTH;
        c = 0;
        case (code)
            1: r = d;
            2: begin
                r = a + d;
                c = (r >= full) ? 1 : 0;
                if (c != 0) r = SAT ? full - 1 : r - full;
            end
            3: begin
                c = (d > a) ? 1 : 0;
                r = a - d;
                if (c != 0) r = SAT ? 0 : r + full;
            end
            4: r = a & d;
            5: r = a | d;
            6: r = a ^ d;
            7: r = 0;
            default: r = a;
        endcase
    endfunction

    // Per-cycle expectations scheduled from each predicted accept.
    bit busy_e [N];
    bit wacc_e [N];
    bit done_e [N];
    bit upd_v  [N];
    int upd_d  [N];
    int upd_c  [N];
    int upd_z  [N];
    bit accw_v [N];
    int accw_d [N];
    int cur_d, cur_c, cur_z;
    int m_acc = 0;
    bit started = 1'b0;

    always @(negedge clk) begin
        int k, r, c;
        k = cyc;
        if (k + 5 < N) begin
            if (started) begin
                if (upd_v[k]) begin
                    cur_d = upd_d[k];
                    cur_c = upd_c[k];
                    cur_z = upd_z[k];
                end
                chk("m_op_ready", 32'(bus.op_ready), 32'(!busy_e[k]));
                chk("m_wacc",     32'(bus.wacc),     32'(wacc_e[k]));
                chk("m_done",     32'(bus.done),     32'(done_e[k]));
                chk("m_acc_d",    32'(bus.acc_d),    32'(cur_d));
                chk("m_carry",    32'(bus.carry),    32'(cur_c));
                chk("m_zero",     32'(bus.zero),     32'(cur_z));
                chk("m_acc_q",    32'(acc_reg),      32'(m_acc));
            end
            if (accw_v[k]) m_acc = accw_d[k];
            if (rst === 1'b1) begin
                started = 1'b1;
                for (int j = k + 1; j <= k + 4; j++) begin
                    busy_e[j] = 1'b0; wacc_e[j] = 1'b0; done_e[j] = 1'b0;
                    upd_v[j] = 1'b0; accw_v[j] = 1'b0;
                end
                upd_v[k+1] = 1'b1; upd_d[k+1] = 0; upd_c[k+1] = 0; upd_z[k+1] = 0;
            end else if (started && bus.op_valid === 1'b1 && !busy_e[k]) begin
                busy_e[k+1] = 1'b1;
                busy_e[k+2] = 1'b1;
                if (bus.op_code == 3'b000) begin
                    done_e[k+2] = 1'b1;
                end else begin
                    model_op(int'(bus.op_code), m_acc, int'(bus.op_data), r, c);
                    busy_e[k+3] = 1'b1;
                    wacc_e[k+2] = 1'b1;
                    done_e[k+3] = 1'b1;
                    upd_v[k+2] = 1'b1; upd_d[k+2] = r; upd_c[k+2] = c;
                    upd_z[k+2] = (r == 0) ? 1 : 0;
                    accw_v[k+2] = 1'b1; accw_d[k+2] = r;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.op_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_wait", 32'(bus.op_ready), 32'd1);
    endtask

    task automatic do_op(input acc_op_t code, input int data, input int ed, input int ec, input int ez);
        wait_ready();
        bus.op_valid = 1'b1; bus.op_code = code; bus.op_data = 8'(data);
        step();
        bus.op_valid = 1'b0;
        chk("exec_wacc", 32'(bus.wacc), 32'd0);
        step();
        chk("write_wacc",  32'(bus.wacc),  32'd1);
        chk("write_acc_d", 32'(bus.acc_d), 32'(ed));
        step();
        chk("settle_done",  32'(bus.done),  32'd1);
        chk("settle_wacc",  32'(bus.wacc),  32'd0);
        chk("settle_acc_q", 32'(acc_reg),   32'(ed));
        chk("settle_carry", 32'(bus.carry), 32'(ec));
        chk("settle_zero",  32'(bus.zero),  32'(ez));
        step();
        chk("back_ready", 32'(bus.op_ready), 32'd1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 2000", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.op_valid = 1'b0; bus.op_code = '0; bus.op_data = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_wacc",  32'(bus.wacc),     32'd0);
        chk("rst_acc_d", 32'(bus.acc_d),    32'd0);
        chk("rst_done",  32'(bus.done),     32'd0);
        chk("rst_carry", 32'(bus.carry),    32'd0);
        chk("rst_zero",  32'(bus.zero),     32'd0);
        step();

        do_op(OP_LOAD, 159, 159, 0, 0);
        do_op(OP_ADD, 200, SAT ? 255 : 103, 1, 0);
        do_op(OP_SUB, 104, SAT ? 151 : 255, SAT ? 0 : 1, 0);

        // op_valid held across two operations.
        wait_ready();
        bus.op_valid = 1'b1; bus.op_code = OP_LOAD; bus.op_data = 8'd5;
        step();
        bus.op_code = OP_XOR; bus.op_data = 8'd3;
        chk("held_busy", 32'(bus.op_ready), 32'd0);
        step();
        chk("held_acc_d1", 32'(bus.acc_d), 32'd5);
        step();
        step();
        chk("held_ready_c4", 32'(bus.op_ready), 32'd1);
        step();
        chk("held_accept_c4", 32'(bus.op_ready), 32'd0);
        bus.op_valid = 1'b0;
        step();
        chk("held_wacc2",  32'(bus.wacc),  32'd1);
        chk("held_acc_d2", 32'(bus.acc_d), 32'd6);
        step();
        chk("held_zero", 32'(bus.zero), 32'd0);
        chk("held_acc_q", 32'(acc_reg), 32'd6);
        step();

        do_op(OP_CLR, 99, 0, 0, 1);
        do_op(OP_LOAD, 255, 255, 0, 0);
        do_op(OP_ADD, 1, SAT ? 255 : 0, 1, SAT ? 0 : 1);

        // NOP: no write, done one cycle earlier, flags untouched.
        wait_ready();
        bus.op_valid = 1'b1; bus.op_code = OP_NOP; bus.op_data = 8'd42;
        step();
        bus.op_valid = 1'b0;
        chk("nop_exec_wacc", 32'(bus.wacc), 32'd0);
        step();
        chk("nop_done",  32'(bus.done),  32'd1);
        chk("nop_wacc",  32'(bus.wacc),  32'd0);
        chk("nop_acc_d", 32'(bus.acc_d), SAT ? 32'd255 : 32'd0);
        chk("nop_carry", 32'(bus.carry), 32'd1);
        chk("nop_zero",  32'(bus.zero),  SAT ? 32'd0 : 32'd1);
        step();
        chk("nop_ready", 32'(bus.op_ready), 32'd1);

        // Reset asserted while in WRITE.
        wait_ready();
        bus.op_valid = 1'b1; bus.op_code = OP_LOAD; bus.op_data = 8'd77;
        step();
        bus.op_valid = 1'b0;
        step();
        chk("rw_wacc", 32'(bus.wacc), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rw_wacc_after",  32'(bus.wacc),     32'd0);
        chk("rw_acc_d_after", 32'(bus.acc_d),    32'd0);
        chk("rw_ready_after", 32'(bus.op_ready), 32'd1);
        chk("rw_done_after",  32'(bus.done),     32'd0);
        chk("rw_acc_q",       32'(acc_reg),      32'd77);
        step();
        step();
        chk("rw_acc_q_hold",  32'(acc_reg),      32'd77);

        do_op(OP_AND, 15, 13, 0, 0);
        do_op(OP_OR, 240, 253, 0, 0);
        do_op(OP_SUB, 254, SAT ? 0 : 255, 1, SAT ? 1 : 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/acc_driver.md
# acc_driver

Write-side controller for the 8-bit accumulator register. It accepts one operation at a time over a valid/ready handshake and computes the new value from the accumulator's current output. It then drives the accumulator's write-enable and data inputs for exactly one cycle, and reports completion and flags. It sits between the instruction sequencer and the accumulator: its `wacc`/`acc_d` outputs feed the accumulator's write port, and the accumulator's output feeds back to `acc_q`.

## Interface
- `WIDTH`, 8, data width of the accumulator path.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `op_valid` input 1: an operation is presented.
- `op_ready` output 1: the driver can accept an operation (IDLE only).
- `op_code` input 3: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 CLR.
- `op_data` input WIDTH: operand.
- `acc_q` input WIDTH: current accumulator output.
- `wacc` output 1: accumulator write enable, one-cycle pulse.
- `acc_d` output WIDTH: accumulator write data.
- `done` output 1: one-cycle pulse when an operation completes.
- `carry` output 1: carry (ADD) or borrow (SUB) of the last write operation.
- `zero` output 1: last written value was 0.

## Operation
- States:
  - IDLE: `op_ready`=1.
  - EXEC: compute.
  - WRITE: `wacc`=1.
  - SETTLE: `done`=1.
- Transitions:
  - IDLE→EXEC on `op_valid & op_ready`; `op_code` and `op_data` are captured at this edge.
  - EXEC→WRITE, except NOP goes EXEC→SETTLE.
  - WRITE→SETTLE.
  - SETTLE→IDLE.
- EXEC registers the result into `acc_d`. `acc_q` is sampled in EXEC.
- Results:
  - LOAD = `op_data`.
  - ADD = `acc_q`+`op_data`.
  - SUB = `acc_q`−`op_data`.
  - AND/OR/XOR are bitwise with `op_data`.
  - CLR = 0.
- Arithmetic is computed at WIDTH+1 bits.
  - ADD: `carry` = bit WIDTH of the sum.
  - SUB: `carry` = 1 when `op_data` > `acc_q` (borrow).
  - Logic ops, LOAD and CLR: `carry` is cleared.
- `carry` and `zero` are updated only when entering WRITE. NOP leaves the flags, `acc_d` and `wacc` untouched.
- `acc_d` holds its value outside WRITE. `wacc` is 1 only in WRITE.
- `op_valid` outside IDLE is ignored and nothing is queued. An upstream source holding `op_valid` is accepted again on the cycle the driver returns to IDLE.
- Reset values: state IDLE, `op_ready`=1, `wacc`=0, `acc_d`=0, `done`=0, `carry`=0, `zero`=0.
- Reset in any state, including WRITE, forces all of the above on the next edge. A write already in WRITE at that edge still lands in the accumulator; no further write is issued.

## Timing
- Accept edge = cycle 0.
  - Cycle 1: EXEC.
  - Cycle 2: WRITE, `wacc`=1 and `acc_d` valid.
  - Cycle 3: SETTLE. The accumulator captured the value at the end of cycle 2, so `acc_q` already shows the new value when `done`=1.
  - Cycle 4: IDLE.
- Throughput: one operation per 4 cycles. A NOP takes 3 cycles (accept, EXEC, SETTLE).
- The driver requires the accumulator to be a single-cycle register (write at edge, output next cycle).

## Configuration
- `ACC_DRIVER_SAT_EN`:
  - Defined: ADD clamps to 2^WIDTH−1 on carry, and SUB clamps to 0 on borrow. `carry` still reports the overflow or borrow.
  - Undefined: ADD and SUB wrap modulo 2^WIDTH.
- Logic ops are unaffected either way.

## Structure
- Shared package `acc_pkg`:
  - `acc_op_t` enum carrying the 3-bit op encodings.
  - `acc_drv_state_t` enum: IDLE, EXEC, WRITE, SETTLE.
  - `ACC_WIDTH` = 8.
- One sub-module, `acc_alu`: combinational result, carry and zero from op, `acc_q` and operand. It contains the saturation logic under `ACC_DRIVER_SAT_EN`.
- `acc_driver` holds the FSM, the capture registers and the output registers.

## Test plan
- Reset held 2 cycles, then released → `op_ready`=1; `wacc`, `acc_d`, `done`, `carry` and `zero` all 0.
- LOAD 159 accepted at cycle 0 → `wacc`=1 with `acc_d`=159 in cycle 2 only; `done` in cycle 3; `acc_q`=159.
- ADD 200 with `acc_q`=159 → `acc_d`=103, `carry`=1 (saturating build: 255, `carry`=1). Then SUB 104 → 255, `carry`=1 (saturating: 0).
- `op_valid` held high across LOAD 5 then XOR 3 → second accept exactly at cycle 4; `acc_d`=6; `zero`=0. CLR → `acc_d`=0, `zero`=1, `carry`=0.
- NOP → no `wacc` pulse; `done` in cycle 2; flags and `acc_d` unchanged.
- `rst` asserted during WRITE of LOAD 77 → next cycle `wacc`=0, `acc_d`=0, `op_ready`=1; `acc_q`=77 (the write at that edge lands); no second write.
